// File: rtl/alu_exec_pkg.sv
// Shared opcodes, EX-stage FSM state type and default widths for the ALU
// execute/write-back stage.
package alu_exec_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int SHAMT_W    = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2
  } ex_state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// Iterative logical shifter: loads an operand and amount, then moves one bit
// position per cycle until the amount counter reaches zero.
module alu_exec_shifter
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dir,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  result,
  output logic               done
);

  logic [DATA_W-1:0]  acc;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_q;

  // dir = 1 shifts right (logical), dir = 0 shifts left
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc   <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      acc   <= din;
      cnt   <= amount;
      dir_q <= dir;
    end else if (cnt != '0) begin
      acc <= dir_q ? (acc >> 1) : (acc << 1);
      cnt <= cnt - SHAMT_W'(1);
    end
  end

  assign result = acc;
  assign done   = (cnt == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute/write-back stage in front of a register file: forwarding at
// issue, single-cycle ALU ops, iterative shifts that stall issue, WB register.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  output logic [ADDR_W-1:0] raddr1,
  output logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [15:0]       retired,
  output logic [1:0]        ex_state
);

  ex_state_t         state;
  logic [2:0]        ex_op;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_a, ex_b, ex_result;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] shift_result;
  logic              shift_done, ex_done, accept, shift_go, wb_valid;

  // Handshake: a transfer happens on a rising edge with in_valid && in_ready.
  // in_ready depends only on EX state (never on in_valid) and drops only
  // while a shift still has bits left to move.
  assign in_ready = !((state == ST_SHIFT) && !shift_done);
  assign accept   = in_valid && in_ready;
  assign ex_done  = (state == ST_EXEC) || ((state == ST_SHIFT) && shift_done);

  assign raddr1 = in_rs1;
  assign raddr2 = in_rs2;

  always_comb begin
    ex_result = ex_a;
    if (state == ST_SHIFT) begin
      ex_result = shift_result;
    end else begin
      case (ex_op)
        OP_ADD:  ex_result = ex_a + ex_b;
        OP_SUB:  ex_result = ex_a - ex_b;
        OP_AND:  ex_result = ex_a & ex_b;
        OP_OR:   ex_result = ex_a | ex_b;
        OP_XOR:  ex_result = ex_a ^ ex_b;
        default: ex_result = ex_a;  // MOV, and shifts by zero
      endcase
    end
  end

  // Youngest producer wins: completing EX result over WB data over the file.
  always_comb begin
    op_a = rdata1;
    op_b = rdata2;
    if (wb_valid && (waddr == in_rs1)) op_a = wdata;
    if (wb_valid && (waddr == in_rs2)) op_b = wdata;
    if (ex_done && (ex_rd == in_rs1))  op_a = ex_result;
    if (ex_done && (ex_rd == in_rs2))  op_b = ex_result;
  end

  assign shift_go = accept && is_shift(in_op) && (op_b[SHAMT_W-1:0] != '0);

  alu_exec_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load   (shift_go),
    .dir    (in_op == OP_SHR),
    .amount (op_b[SHAMT_W-1:0]),
    .din    (op_a),
    .result (shift_result),
    .done   (shift_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      ex_op <= OP_ADD;
      ex_rd <= '0;
      ex_a  <= '0;
      ex_b  <= '0;
    end else if (accept) begin
      state <= shift_go ? ST_SHIFT : ST_EXEC;
      ex_op <= in_op;
      ex_rd <= in_rd;
      ex_a  <= op_a;
      ex_b  <= op_b;
    end else if (ex_done) begin
      state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      retired  <= '0;
    end else begin
      wb_valid <= ex_done;
      if (ex_done) begin
        waddr <= ex_rd;
        wdata <= ex_result;
      end
      if (wb_valid) retired <= retired + 16'd1;
    end
  end

  // The file writes on the same edge that samples reset, so a WB entry caught
  // by reset must already be masked here to be dropped.
  assign we       = wb_valid && rst;
  assign busy     = (state != ST_IDLE) || wb_valid;
  assign ex_state = state;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage driving a behavioural register file
// preloaded with r0..r7 = 0x0A..0x11.
module tb_alu_exec_stage;
  import alu_exec_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'd0;
  logic [AW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [AW-1:0] raddr1, raddr2, waddr;
  logic [DW-1:0] rdata1, rdata2, wdata;
  logic          we, busy;
  logic [15:0]   retired;
  logic [1:0]    ex_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
    .retired(retired), .ex_state(ex_state)
  );

  // Register file model with a bench-side preload/poke port
  logic [DW-1:0] regs [8];
  logic          preload = 1'b0, poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) regs[i] <= DW'(10 + i);
    end else if (poke_en) begin
      regs[poke_addr] <= poke_data;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  // Write log: cycle index (edges so far) when we is seen high
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t wr_log[$];
  logic [AW+DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (we) begin
      wr_t e;
      e.cyc = cyc; e.addr = waddr; e.data = wdata;
      wr_log.push_back(e);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Holds the instruction until it transfers; returns the accept index
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       output int acc_cyc, output int stalls);
    logic rdy;
    bit   done;
    done = 0;
    stalls = 0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    while (!done) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        done = 1;
      end else begin
        stalls++;
        if (stalls > 40) begin
          checks++; errors++;
          $display("FAIL issue_timeout op=%0d got no accept in 40 cycles exp accept", op);
          done = 1;
        end
      end
    end
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    preload = 1'b1; rst = 1'b0;
    idle(2);
    preload = 1'b0;
    in_rs1 = 3'd5; in_rs2 = 3'd6;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", retired); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (waddr !== 3'd0 || wdata !== 8'h00) begin errors++; $display("FAIL reset_wport got %0d/%h exp 0/00", waddr, wdata); end
    checks++; if (ex_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", ex_state); end
    checks++; if (raddr1 !== 3'd5 || raddr2 !== 3'd6) begin errors++; $display("FAIL reset_raddr got %0d/%0d exp 5/6", raddr1, raddr2); end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_independent();
    int a, s;
    wr_log.delete();
    issue(OP_ADD, 3'd0, 3'd1, 3'd2, a, s);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL add_we_early got %0b exp 0", we); end
    idle(1);
    checks++; if (we !== 1'b1 || waddr !== 3'd0 || wdata !== 8'h17) begin
      errors++; $display("FAIL add_wb got we=%0b r%0d=%h exp we=1 r0=17", we, waddr, wdata); end
    idle(1);
    issue(OP_SUB, 3'd3, 3'd4, 3'd7, s, s);
    idle(2);
    checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL indep_count got %0d exp 2", wr_log.size()); end
    else begin
      checks++; if (wr_log[0].cyc != a + 1) begin errors++; $display("FAIL add_latency got %0d exp %0d", wr_log[0].cyc, a + 1); end
      checks++; if (wr_log[1].addr !== 3'd3 || wr_log[1].data !== 8'hFD) begin
        errors++; $display("FAIL sub_wrap got r%0d=%h exp r3=fd", wr_log[1].addr, wr_log[1].data); end
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, s;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h16; exp_d[1] = 8'h1D; exp_d[2] = 8'h1F;
    wr_log.delete();
    issue(OP_ADD, 3'd5, 3'd1, 3'd1, a0, s);
    issue(OP_XOR, 3'd6, 3'd5, 3'd1, a1, s);
    issue(OP_OR,  3'd7, 3'd5, 3'd6, a2, s);
    idle(3);
    checks++; if (a1 != a0 + 1 || a2 != a0 + 2) begin
      errors++; $display("FAIL b2b_bubbles got accepts %0d,%0d,%0d exp consecutive", a0, a1, a2); end
    checks++; if (wr_log.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", wr_log.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_log[i].addr !== AW'(5 + i) || wr_log[i].data !== exp_d[i] || wr_log[i].cyc != a0 + i + 1) begin
          errors++; $display("FAIL b2b_wr%0d got r%0d=%h @%0d exp r%0d=%h @%0d", i, wr_log[i].addr,
                             wr_log[i].data, wr_log[i].cyc, 5 + i, exp_d[i], a0 + i + 1);
        end
      end
    end
    checks++; if (regs[7] !== 8'h1F) begin errors++; $display("FAIL b2b_r7 got %h exp 1f", regs[7]); end
  endtask

  task automatic test_shift();
    int a, b, c, d, s;
    poke_en = 1'b1; poke_addr = 3'd2; poke_data = 8'h03;
    idle(1);
    poke_en = 1'b0;
    wr_log.delete();
    issue(OP_SHL, 3'd4, 3'd1, 3'd2, a, s);
    checks++; if (in_ready !== 1'b0 || ex_state !== ST_SHIFT) begin
      errors++; $display("FAIL shl_stall_start got ready=%0b state=%0d exp 0/2", in_ready, ex_state); end
    issue(OP_ADD, 3'd0, 3'd1, 3'd4, b, s);
    checks++; if (s != 3 || b != a + 4) begin
      errors++; $display("FAIL shl_stall got stalls=%0d accept=%0d exp 3/%0d", s, b, a + 4); end
    idle(3);
    issue(OP_SHR, 3'd5, 3'd1, 3'd4, c, s);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL shr0_ready got %0b exp 1", in_ready); end
    idle(2);
    issue(OP_SHR, 3'd6, 3'd4, 3'd2, d, s);
    idle(6);
    checks++; if (wr_log.size() != 4) begin errors++; $display("FAIL shift_count got %0d exp 4", wr_log.size()); end
    else begin
      checks++; if (wr_log[0].addr !== 3'd4 || wr_log[0].data !== 8'h58 || wr_log[0].cyc != a + 4) begin
        errors++; $display("FAIL shl3 got r%0d=%h @%0d exp r4=58 @%0d", wr_log[0].addr, wr_log[0].data, wr_log[0].cyc, a + 4); end
      checks++; if (wr_log[1].addr !== 3'd0 || wr_log[1].data !== 8'h63 || wr_log[1].cyc != b + 1) begin
        errors++; $display("FAIL add_after_shl got r%0d=%h @%0d exp r0=63 @%0d", wr_log[1].addr, wr_log[1].data, wr_log[1].cyc, b + 1); end
      checks++; if (wr_log[2].addr !== 3'd5 || wr_log[2].data !== 8'h0B || wr_log[2].cyc != c + 1) begin
        errors++; $display("FAIL shr0 got r%0d=%h @%0d exp r5=0b @%0d", wr_log[2].addr, wr_log[2].data, wr_log[2].cyc, c + 1); end
      checks++; if (wr_log[3].addr !== 3'd6 || wr_log[3].data !== 8'h0B || wr_log[3].cyc != d + 4) begin
        errors++; $display("FAIL shr3 got r%0d=%h @%0d exp r6=0b @%0d", wr_log[3].addr, wr_log[3].data, wr_log[3].cyc, d + 4); end
    end
  endtask

  task automatic test_reset_mid();
    int a, s;
    wr_log.delete();
    issue(OP_ADD, 3'd7, 3'd1, 3'd1, a, s);
    issue(OP_SHL, 3'd3, 3'd1, 3'd2, a, s);
    checks++; if (we !== 1'b1 || ex_state !== ST_SHIFT) begin
      errors++; $display("FAIL mid_setup got we=%0b state=%0d exp 1/2", we, ex_state); end
    rst = 1'b0;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL mid_we_masked got %0b exp 0", we); end
    idle(2);
    rst = 1'b1;
    idle(6);
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL mid_no_write got %0d writes exp 0", wr_log.size()); end
    checks++; if (regs[7] !== 8'h1F || regs[3] !== 8'hFD) begin
      errors++; $display("FAIL mid_regs got r7=%h r3=%h exp 1f/fd", regs[7], regs[3]); end
    checks++; if (retired !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_state got retired=%0d busy=%0b ready=%0b exp 0/0/1", retired, busy, in_ready); end
  endtask

  task automatic test_counter();
    logic [2:0]    ops [6];
    logic [DW-1:0] ref_regs [8];
    logic [DW-1:0] x, y, res;
    logic [AW-1:0] rd, rs1, rs2;
    logic [2:0]    op;
    int a, a0, s;
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND;
    ops[3] = OP_OR;  ops[4] = OP_XOR; ops[5] = OP_MOV;
    for (int i = 0; i < 8; i++) ref_regs[i] = regs[i];
    wr_log.delete(); exp_q.delete();
    a0 = 0;
    for (int j = 0; j < 300; j++) begin
      op = ops[j % 6];
      rd = AW'((j * 3 + 1) % 8); rs1 = AW'((j * 5 + 2) % 8); rs2 = AW'((j * 7 + 3) % 8);
      x = ref_regs[rs1]; y = ref_regs[rs2];
      case (op)
        OP_ADD:  res = x + y;
        OP_SUB:  res = x - y;
        OP_AND:  res = x & y;
        OP_OR:   res = x | y;
        OP_XOR:  res = x ^ y;
        default: res = x;
      endcase
      ref_regs[rd] = res;
      exp_q.push_back({rd, res});
      issue(op, rd, rs1, rs2, a, s);
      if (j == 0) a0 = a;
    end
    idle(4);
    checks++; if (a != a0 + 299) begin errors++; $display("FAIL cnt_throughput got last accept %0d exp %0d", a, a0 + 299); end
    checks++; if (retired !== 16'd300) begin errors++; $display("FAIL cnt_retired got %0d exp 300", retired); end
    checks++; if (wr_log.size() != 300) begin errors++; $display("FAIL cnt_writes got %0d exp 300", wr_log.size()); end
    else begin
      for (int k = 0; k < 300; k++) begin
        checks++;
        if ({wr_log[k].addr, wr_log[k].data} !== exp_q[k] || wr_log[k].cyc != a0 + k + 1) begin
          errors++; $display("FAIL cnt_wr%0d got %h @%0d exp %h @%0d", k, {wr_log[k].addr, wr_log[k].data},
                             wr_log[k].cyc, exp_q[k], a0 + k + 1);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (regs[i] !== ref_regs[i]) begin errors++; $display("FAIL cnt_r%0d got %h exp %h", i, regs[i], ref_regs[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_back_to_back();
    test_shift();
    test_reset_mid();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish before 200000");
    $fatal(1);
  end

endmodule
